// File: rtl/axi_pkg.sv
// Shared encodings for the AXI3 burst RAM: FSM states, response/burst codes
// and the request-legality helper used on both address channels.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDATA = 2'd1,
        WDATA = 2'd2,
        WRESP = 2'd3
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // WRAP and the reserved burst code are served as INCR but flagged as errors.
    function automatic logic [1:0] req_resp(input logic [1:0] burst, input logic [2:0] size);
        return ((burst != FIXED && burst != INCR) || size != SIZE_WORD) ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_ram_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping every cycle; bit 0 is
// used by the RAM as a data-channel stall request.
module axi_burst_ram_lfsr
    import axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    logic feedback;

    assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[14:0], feedback};
        end
    end

endmodule

// File: rtl/axi_burst_ram.sv
// AXI3 slave memory model: one FIXED/INCR burst (up to 16 x 32-bit beats) in flight.
// Define AXI_BURST_RAM_RAND_STALL_EN to throttle R/W data with an LFSR.
module axi_burst_ram
    import axi_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter bit RD_PRIO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [31:0] mem [DEPTH];

    state_t state, state_nx;

    logic [3:0]        id_q;
    logic [3:0]        len_q;
    logic [3:0]        beat_q;
    logic [ADDR_W-1:0] addr_q;
    logic              fixed_q;
    logic [1:0]        resp_q;
    logic              over_q;

    logic ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic stall;
    logic do_fetch;
    logic wr_en;

    logic [ADDR_W-1:0] fetch_addr;
    logic [3:0]        fetch_beat;
    logic [3:0]        fetch_len;
    logic              fetch_fixed;

    logic unused_ok;
    assign unused_ok = ^{araddr[31:ADDR_W+2], araddr[1:0], arlen[7:4], arlock, arcache, arprot,
                         awaddr[31:ADDR_W+2], awaddr[1:0], awlen[7:4], awlock, awcache, awprot,
                         wid};

`ifdef AXI_BURST_RAM_RAND_STALL_EN
    logic [15:0] lfsr_value;

    axi_burst_ram_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_value)
    );

    assign stall = lfsr_value[0];
`else
    assign stall = 1'b0;
`endif

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic fixed);
        return fixed ? a : a + ADDR_ONE;
    endfunction

    // Address ready is combinational in IDLE; the reset term keeps it low while rst is held.
    assign arready = rst && (state == IDLE) && (!awvalid || RD_PRIO);
    assign awready = rst && (state == IDLE) && (!arvalid || !RD_PRIO);
    assign wready  = (state == WDATA) && !stall;

    assign ar_hs = arvalid && arready;
    assign aw_hs = awvalid && awready;
    assign r_hs  = rvalid && rready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign wr_en = w_hs && !over_q;

    // First beat is fetched straight from the AR channel so rvalid follows the handshake by one cycle.
    always_comb begin
        fetch_addr  = addr_q;
        fetch_beat  = beat_q;
        fetch_len   = len_q;
        fetch_fixed = fixed_q;
        if (state == IDLE) begin
            fetch_addr  = araddr[ADDR_W+1:2];
            fetch_beat  = 4'd0;
            fetch_len   = arlen[3:0];
            fetch_fixed = (arburst == FIXED);
        end
    end

    assign do_fetch = !stall && (ar_hs || (state == RDATA && (!rvalid || (rready && !rlast))));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    state_nx = RDATA;
                end else if (aw_hs) begin
                    state_nx = WDATA;
                end
            end
            RDATA:   if (r_hs && rlast) state_nx = IDLE;
            WDATA:   if (w_hs && wlast) state_nx = WRESP;
            WRESP:   if (b_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            fixed_q <= 1'b0;
            resp_q  <= OKAY;
            over_q  <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= OKAY;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= OKAY;
            bvalid  <= 1'b0;
        end else begin
            state <= state_nx;

            if (ar_hs) begin
                id_q    <= arid;
                len_q   <= arlen[3:0];
                fixed_q <= (arburst == FIXED);
                resp_q  <= req_resp(arburst, arsize);
                addr_q  <= araddr[ADDR_W+1:2];
                beat_q  <= '0;
                rid     <= arid;
                rresp   <= req_resp(arburst, arsize);
            end else if (aw_hs) begin
                id_q    <= awid;
                len_q   <= awlen[3:0];
                fixed_q <= (awburst == FIXED);
                resp_q  <= req_resp(awburst, awsize);
                addr_q  <= awaddr[ADDR_W+1:2];
                beat_q  <= '0;
                over_q  <= 1'b0;
            end

            if (do_fetch) begin
                rdata  <= mem[fetch_addr];
                rlast  <= (fetch_beat == fetch_len);
                rvalid <= 1'b1;
                addr_q <= next_addr(fetch_addr, fetch_fixed);
                beat_q <= fetch_beat + 4'd1;
            end else if (r_hs) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end

            // Beats beyond len are accepted but not stored; over_q marks that region.
            if (w_hs) begin
                if (!over_q) begin
                    addr_q <= next_addr(addr_q, fixed_q);
                    if (beat_q == len_q) begin
                        over_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + 4'd1;
                    end
                end
                if (wlast) begin
                    bvalid <= 1'b1;
                    bid    <= id_q;
                    bresp  <= resp_q | ((over_q || beat_q != len_q) ? SLVERR : OKAY);
                end
            end

            if (b_hs) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[addr_q][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
